// File: rtl/snitch_tcdm_bank_arb.sv
// Single-port TCDM bank arbiter: starvation > priority > round-robin selection with
// lock-in under bank backpressure and a fixed-latency response return path.
module snitch_tcdm_bank_arb #(
   parameter int unsigned NumInp                = 4,
   parameter int unsigned AddrWidth             = 10,
   parameter int unsigned DataWidth             = 64,
   parameter int unsigned MemoryResponseLatency = 1,
   parameter int unsigned StarveThresh          = 8
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic [NumInp-1:0]                     req_valid_i,
   output logic [NumInp-1:0]                     req_ready_o,
   input  logic [NumInp-1:0]                     req_prio_i,
   input  logic [NumInp-1:0][AddrWidth-1:0]      req_addr_i,
   input  logic [NumInp-1:0]                     req_write_i,
   input  logic [NumInp-1:0][DataWidth-1:0]      req_data_i,
   input  logic [NumInp-1:0][DataWidth/8-1:0]    req_strb_i,
   output logic                                  mem_valid_o,
   input  logic                                  mem_ready_i,
   output logic [AddrWidth-1:0]                  mem_addr_o,
   output logic                                  mem_write_o,
   output logic [DataWidth-1:0]                  mem_data_o,
   output logic [DataWidth/8-1:0]                mem_strb_o,
   input  logic [DataWidth-1:0]                  mem_rdata_i,
   output logic [NumInp-1:0]                     rsp_valid_o,
   output logic [DataWidth-1:0]                  rsp_data_o
);

   localparam int unsigned IdxW = $clog2(NumInp);
   localparam int unsigned CntW = $clog2(StarveThresh + 1);
   localparam int unsigned Lat  = MemoryResponseLatency;

   logic [IdxW-1:0]              rr_ptr_q, rr_ptr_d;
   logic                         lock_q, lock_d;
   logic [IdxW-1:0]              lock_idx_q, lock_idx_d;
   logic [NumInp-1:0][CntW-1:0]  cnt_q, cnt_d;
   logic [Lat-1:0]               sr_vld_q, sr_vld_d;
   logic [Lat-1:0][IdxW-1:0]     sr_idx_q, sr_idx_d;

   logic [NumInp-1:0] starved, prio_req, cand;
   logic [IdxW-1:0]   winner;
   logic              found, lock_hold, hs;
   int unsigned       idx;

   always_comb begin
      for (int i = 0; i < NumInp; i++) begin
         starved[i] = req_valid_i[i] && (cnt_q[i] == CntW'(StarveThresh));
      end
      prio_req = req_valid_i & req_prio_i;
      if (|starved)       cand = starved;
      else if (|prio_req) cand = prio_req;
      else                cand = req_valid_i;
   end

   // Round-robin scan from rr_ptr; an active lock overrides the class decision.
   always_comb begin
      winner = rr_ptr_q;
      found  = 1'b0;
      idx    = 0;
      for (int unsigned k = 0; k < NumInp; k++) begin
         idx = 32'(rr_ptr_q) + k;
         if (idx >= NumInp) idx = idx - NumInp;
         if (!found && cand[idx]) begin
            winner = IdxW'(idx);
            found  = 1'b1;
         end
      end
      lock_hold = lock_q && req_valid_i[lock_idx_q];
      if (lock_hold) winner = lock_idx_q;
   end

   always_comb begin
      mem_valid_o = rst_ni & (|req_valid_i);
      hs          = mem_valid_o & mem_ready_i;
      req_ready_o = '0;
      if (mem_valid_o) req_ready_o[winner] = mem_ready_i;
      mem_addr_o  = req_addr_i[winner];
      mem_write_o = req_write_i[winner];
      mem_data_o  = req_data_i[winner];
      mem_strb_o  = req_strb_i[winner];
      rsp_data_o  = mem_rdata_i;
      rsp_valid_o = '0;
      if (sr_vld_q[Lat-1]) rsp_valid_o[sr_idx_q[Lat-1]] = 1'b1;
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (hs) rr_ptr_d = (32'(winner) == NumInp - 1) ? '0 : winner + IdxW'(1);
      lock_d     = mem_valid_o & ~mem_ready_i;
      lock_idx_d = winner;
      for (int i = 0; i < NumInp; i++) begin
         if (!req_valid_i[i] || (hs && (winner == IdxW'(i)))) cnt_d[i] = '0;
         else if (cnt_q[i] != CntW'(StarveThresh))            cnt_d[i] = cnt_q[i] + CntW'(1);
         else                                                  cnt_d[i] = cnt_q[i];
      end
      sr_vld_d    = sr_vld_q;
      sr_idx_d    = sr_idx_q;
      sr_vld_d[0] = hs;
      sr_idx_d[0] = winner;
      for (int k = 1; k < Lat; k++) begin
         sr_vld_d[k] = sr_vld_q[k-1];
         sr_idx_d[k] = sr_idx_q[k-1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rr_ptr_q   <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         cnt_q      <= '0;
         sr_vld_q   <= '0;
         sr_idx_q   <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         cnt_q      <= cnt_d;
         sr_vld_q   <= sr_vld_d;
         sr_idx_q   <= sr_idx_d;
      end
   end

   // A locked requester must hold its request until the bank accepts it.
   lock_drop_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 lock_q |-> req_valid_i[lock_idx_q]);

endmodule

// File: tb/tb_snitch_tcdm_bank_arb.sv
// Directed bench for snitch_tcdm_bank_arb: a latency-1 and a latency-3 instance share stimulus.
module tb_snitch_tcdm_bank_arb;

   localparam int unsigned N  = 4;
   localparam int unsigned AW = 10;
   localparam int unsigned DW = 64;

   logic                     clk = 1'b0;
   logic                     rst_ni;
   logic [N-1:0]             req_valid, req_prio, req_write;
   logic [N-1:0][AW-1:0]     req_addr;
   logic [N-1:0][DW-1:0]     req_data;
   logic [N-1:0][DW/8-1:0]   req_strb;
   logic                     mem_ready;
   logic [DW-1:0]            mem_rdata;

   logic [N-1:0]    req_ready, rsp_valid, req_ready3, rsp_valid3;
   logic            mem_valid, mem_write, mem_valid3, mem_write3;
   logic [AW-1:0]   mem_addr, mem_addr3;
   logic [DW-1:0]   mem_data, mem_data3, rsp_data, rsp_data3;
   logic [DW/8-1:0] mem_strb, mem_strb3;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   snitch_tcdm_bank_arb #(.NumInp(N), .AddrWidth(AW), .DataWidth(DW),
      .MemoryResponseLatency(1), .StarveThresh(4)) u_dut (
      .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_prio_i(req_prio), .req_addr_i(req_addr), .req_write_i(req_write),
      .req_data_i(req_data), .req_strb_i(req_strb), .mem_valid_o(mem_valid),
      .mem_ready_i(mem_ready), .mem_addr_o(mem_addr), .mem_write_o(mem_write),
      .mem_data_o(mem_data), .mem_strb_o(mem_strb), .mem_rdata_i(mem_rdata),
      .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data));

   snitch_tcdm_bank_arb #(.NumInp(N), .AddrWidth(AW), .DataWidth(DW),
      .MemoryResponseLatency(3), .StarveThresh(4)) u_dut3 (
      .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_ready_o(req_ready3),
      .req_prio_i(req_prio), .req_addr_i(req_addr), .req_write_i(req_write),
      .req_data_i(req_data), .req_strb_i(req_strb), .mem_valid_o(mem_valid3),
      .mem_ready_i(mem_ready), .mem_addr_o(mem_addr3), .mem_write_o(mem_write3),
      .mem_data_o(mem_data3), .mem_strb_o(mem_strb3), .mem_rdata_i(mem_rdata),
      .rsp_valid_o(rsp_valid3), .rsp_data_o(rsp_data3));

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      req_valid = '0;
      req_prio  = '0;
      repeat (n) next();
   endtask

   task automatic test_reset();
      rst_ni    = 1'b0;
      req_valid = 4'hF;
      mem_ready = 1'b1;
      next();
      next();
      @(negedge clk);
      n_cmp++; if (mem_valid !== 1'b0) begin n_err++; $display("FAIL rst_mem_valid: got %b want 0", mem_valid); end
      n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
      n_cmp++; if (rsp_valid !== 4'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0000", rsp_valid); end
      n_cmp++; if (rsp_valid3 !== 4'b0) begin n_err++; $display("FAIL rst_rsp_valid3: got %b want 0000", rsp_valid3); end
      next();
      rst_ni = 1'b1;
      idle(2);
      @(negedge clk);
      n_cmp++; if (mem_valid !== 1'b0) begin n_err++; $display("FAIL idle_mem_valid: got %b want 0", mem_valid); end
      next();
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp_g, exp_r;
      int g;
      req_valid = 4'hF;
      req_prio  = '0;
      mem_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         g     = k % 4;
         exp_g = 4'b0001 << g;
         exp_r = (k == 0) ? 4'b0000 : (4'b0001 << ((k - 1) % 4));
         @(negedge clk);
         n_cmp++; if (req_ready !== exp_g) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp_g); end
         n_cmp++; if (mem_addr !== AW'(10'h100 + g)) begin n_err++; $display("FAIL rr_addr[%0d]: got %h want %h", k, mem_addr, 10'h100 + g); end
         n_cmp++; if (mem_data !== DW'(64'hD0 + g)) begin n_err++; $display("FAIL rr_data[%0d]: got %h want %h", k, mem_data, 64'hD0 + g); end
         n_cmp++; if (rsp_valid !== exp_r) begin n_err++; $display("FAIL rr_rsp[%0d]: got %b want %b", k, rsp_valid, exp_r); end
         next();
      end
      req_valid = '0;
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 4'b0001) begin n_err++; $display("FAIL rr_rsp_last: got %b want 0001", rsp_valid); end
      n_cmp++; if (mem_valid !== 1'b0) begin n_err++; $display("FAIL rr_idle_valid: got %b want 0", mem_valid); end
      idle(4);
   endtask

   task automatic test_priority_starve();
      int seq [10];
      logic [N-1:0] exp_g;
      seq = '{2, 2, 2, 2, 0, 2, 2, 2, 2, 0};
      req_valid = 4'b0101;
      req_prio  = 4'b0100;
      mem_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         exp_g = 4'b0001 << seq[k];
         @(negedge clk);
         n_cmp++; if (req_ready !== exp_g) begin n_err++; $display("FAIL starve_grant[%0d]: got %b want %b", k, req_ready, exp_g); end
         next();
      end
      idle(4);
   endtask

   task automatic test_lock();
      req_valid = 4'b0011;
      req_prio  = 4'b0000;
      mem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) req_prio = 4'b0001;
         @(negedge clk);
         n_cmp++; if (mem_addr !== 10'h101) begin n_err++; $display("FAIL lock_addr[%0d]: got %h want 101", k, mem_addr); end
         n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL lock_ready[%0d]: got %b want 0000", k, req_ready); end
         next();
      end
      mem_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL lock_release: got %b want 0010", req_ready); end
      n_cmp++; if (mem_addr !== 10'h101) begin n_err++; $display("FAIL lock_release_addr: got %h want 101", mem_addr); end
      next();
      @(negedge clk);
      n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL lock_after: got %b want 0001", req_ready); end
      next();
      idle(4);
   endtask

   task automatic test_latency();
      logic [N-1:0] exp_r;
      req_valid = 4'b0100;
      mem_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (req_ready3 !== 4'b0100) begin n_err++; $display("FAIL lat_grant: got %b want 0100", req_ready3); end
      n_cmp++; if (mem_write3 !== 1'b0) begin n_err++; $display("FAIL lat_write: got %b want 0", mem_write3); end
      next();
      req_valid = '0;
      for (int k = 1; k <= 4; k++) begin
         exp_r = (k == 3) ? 4'b0100 : 4'b0000;
         @(negedge clk);
         n_cmp++; if (rsp_valid3 !== exp_r) begin n_err++; $display("FAIL lat3_rsp[t+%0d]: got %b want %b", k, rsp_valid3, exp_r); end
         if (k == 1) begin
            n_cmp++; if (rsp_valid !== 4'b0100) begin n_err++; $display("FAIL lat1_rsp: got %b want 0100", rsp_valid); end
         end
         if (k == 3) begin
            n_cmp++; if (rsp_data3 !== 64'hCAFE_0000_1234_5678) begin n_err++; $display("FAIL lat3_data: got %h want cafe000012345678", rsp_data3); end
         end
         next();
      end
      idle(2);
   endtask

   task automatic test_reset_midflight();
      req_valid = 4'b0010;
      mem_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL mid_grant: got %b want 0010", req_ready); end
      next();
      rst_ni    = 1'b0;
      req_valid = 4'hF;
      @(negedge clk);
      n_cmp++; if (mem_valid3 !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", mem_valid3); end
      n_cmp++; if (req_ready3 !== 4'b0) begin n_err++; $display("FAIL mid_rst_ready: got %b want 0000", req_ready3); end
      n_cmp++; if (rsp_valid !== 4'b0010) begin n_err++; $display("FAIL mid_lat1_rsp: got %b want 0010", rsp_valid); end
      next();
      rst_ni    = 1'b1;
      req_valid = '0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_cmp++; if (rsp_valid3 !== 4'b0) begin n_err++; $display("FAIL mid_rsp3[%0d]: got %b want 0000", k, rsp_valid3); end
         next();
      end
      req_valid = 4'hF;
      @(negedge clk);
      n_cmp++; if (req_ready3 !== 4'b0001) begin n_err++; $display("FAIL mid_rr_ptr: got %b want 0001", req_ready3); end
      next();
      idle(2);
   endtask

   initial begin
      rst_ni    = 1'b0;
      req_valid = '0;
      req_prio  = '0;
      mem_ready = 1'b1;
      mem_rdata = 64'hCAFE_0000_1234_5678;
      for (int i = 0; i < N; i++) begin
         req_addr[i]  = AW'(10'h100 + i);
         req_data[i]  = DW'(64'hD0 + i);
         req_strb[i]  = 8'hFF;
         req_write[i] = 1'(i % 2);
      end
      test_reset();
      test_round_robin();
      test_priority_starve();
      test_lock();
      test_latency();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
